// File: rtl/vga_pkg.sv
// Shared VGA scan widths, screen size, colour type and blink state encoding.
package vga_pkg;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int H_RES = 640;
  localparam int V_RES = 480;

  typedef logic [15:0] color_t;
  localparam color_t DEF_BG_COLOR = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_STEADY,
    ST_BLINK_ON,
    ST_BLINK_OFF
  } blink_state_t;
endpackage

// File: rtl/sprite_blink_fsm.sv
// Blink state machine and vsync-driven animation frame counter; advances only on vsync_tick.
// isplay low forces and holds frame 0, divider 0 and STEADY.
module sprite_blink_fsm import vga_pkg::*; #(
  parameter int FRAMES       = 1,
  parameter int FRAME_DIV    = 8,
  parameter int BLINK_PERIOD = 16,
  parameter int BLINK_COUNT  = 6,
  parameter int FW           = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vsync_tick,
  input  logic          blink_req,
  input  logic          isplay,
  output logic          vis,
  output logic [FW-1:0] frame
);
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int PW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int TW = $clog2(BLINK_COUNT + 1);

  logic [DW-1:0] r_div;
  logic [FW-1:0] r_frame;
  blink_state_t  r_state, w_state_nxt;
  logic [PW-1:0] r_hp, w_hp_nxt;
  logic [TW-1:0] r_tog, w_tog_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_frame <= '0;
    end else if (!isplay) begin
      r_div   <= '0;
      r_frame <= '0;
    end else if (vsync_tick) begin
      if (r_div == DW'(FRAME_DIV - 1)) begin
        r_div   <= '0;
        r_frame <= (r_frame == FW'(FRAMES - 1)) ? '0 : r_frame + 1'b1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STEADY;
      r_hp    <= '0;
      r_tog   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hp    <= w_hp_nxt;
      r_tog   <= w_tog_nxt;
    end
  end

  // blink_req outranks the tick that would end the sequence
  always_comb begin
    w_state_nxt = r_state;
    w_hp_nxt    = r_hp;
    w_tog_nxt   = r_tog;
    if (!isplay) begin
      w_state_nxt = ST_STEADY;
      w_hp_nxt    = '0;
      w_tog_nxt   = '0;
    end else if (blink_req) begin
      w_state_nxt = ST_BLINK_OFF;
      w_hp_nxt    = '0;
      w_tog_nxt   = '0;
    end else if (vsync_tick && r_state != ST_STEADY) begin
      if (r_hp == PW'(BLINK_PERIOD - 1)) begin
        w_hp_nxt = '0;
        if (r_tog == TW'(BLINK_COUNT - 1)) begin
          w_state_nxt = ST_STEADY;
          w_tog_nxt   = '0;
        end else begin
          w_state_nxt = (r_state == ST_BLINK_ON) ? ST_BLINK_OFF : ST_BLINK_ON;
          w_tog_nxt   = r_tog + 1'b1;
        end
      end else begin
        w_hp_nxt = r_hp + 1'b1;
      end
    end
  end

  assign vis   = (r_state != ST_BLINK_OFF);
  assign frame = r_frame;
endmodule

// File: rtl/hint_sprite_anim.sv
// Animated, blinking sprite overlay; 2-cycle registered pixel pipeline, one pixel/clk, no backpressure.
// Build with HINT_SPRITE_TRANSPARENT_EN to make KEY_COLOR pixels transparent.
module hint_sprite_anim import vga_pkg::*; #(
  parameter int     WIDTH        = 177,
  parameter int     HEIGHT       = 26,
  parameter int     FRAMES       = 1,
  parameter int     FRAME_DIV    = 8,
  parameter int     BLINK_PERIOD = 16,
  parameter int     BLINK_COUNT  = 6,
  parameter color_t BG_COLOR     = DEF_BG_COLOR,
  parameter color_t KEY_COLOR    = 16'h0000,
  parameter int     ADDR_W       = $clog2(FRAMES * WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [X_W-1:0]    posx,
  input  logic [Y_W-1:0]    posy,
  input  logic              isplay,
  input  logic              vsync_tick,
  input  logic              blink_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  color_t            rom_data,
  output color_t            color,
  output logic              is_display
);
  localparam int FW          = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int FRAME_WORDS = WIDTH * HEIGHT;
`ifdef HINT_SPRITE_TRANSPARENT_EN
  localparam bit P_TRANSP_EN = 1'b1;
`else
  localparam bit P_TRANSP_EN = 1'b0;
`endif

  logic          w_vis;
  logic [FW-1:0] w_frame;
  logic [X_W:0]  w_xend;
  logic [Y_W:0]  w_yend;
  logic [X_W-1:0] w_dx;
  logic [Y_W-1:0] w_dy;
  logic          w_in_win, w_hit, w_show;
  logic          r_hit_d1;

  sprite_blink_fsm #(
    .FRAMES      (FRAMES),
    .FRAME_DIV   (FRAME_DIV),
    .BLINK_PERIOD(BLINK_PERIOD),
    .BLINK_COUNT (BLINK_COUNT),
    .FW          (FW)
  ) u_blink (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync_tick(vsync_tick),
    .blink_req (blink_req),
    .isplay    (isplay),
    .vis       (w_vis),
    .frame     (w_frame)
  );

  // One extra bit on the far edges so sprites hanging off the right/bottom don't wrap
  assign w_xend   = {1'b0, posx} + (X_W+1)'(WIDTH);
  assign w_yend   = {1'b0, posy} + (Y_W+1)'(HEIGHT);
  assign w_in_win = (x >= posx) && ({1'b0, x} < w_xend) &&
                    (y >= posy) && ({1'b0, y} < w_yend);
  assign w_hit    = w_in_win && isplay && w_vis;

  assign w_dx     = x - posx;
  assign w_dy     = y - posy;
  assign rom_addr = ADDR_W'(32'(w_frame) * 32'(FRAME_WORDS) + 32'(w_dy) * 32'(WIDTH) + 32'(w_dx));

  assign w_show = r_hit_d1 && !(P_TRANSP_EN && rom_data == KEY_COLOR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_d1   <= 1'b0;
      color      <= BG_COLOR;
      is_display <= 1'b0;
    end else begin
      r_hit_d1   <= w_hit;
      color      <= w_show ? rom_data : BG_COLOR;
      is_display <= w_show;
    end
  end
endmodule

// File: tb/tb_hint_sprite_anim.sv
// Directed bench for hint_sprite_anim with a scoreboard of expected pixels.
module tb_hint_sprite_anim;
  localparam int W = 177, H = 26, NF = 4, FDIV = 2, BP = 16, BC = 6;
  localparam int AW = $clog2(NF * W * H);
  localparam logic [15:0] BG = 16'hFFFF;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [9:0]    x = '0, posx = 10'd100;
  logic [8:0]    y = '0, posy = 9'd50;
  logic          isplay = 1'b1, vsync_tick = 1'b0, blink_req = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = '0, color;
  logic          is_display;

  always #5 clk = ~clk;

  hint_sprite_anim #(
    .WIDTH(W), .HEIGHT(H), .FRAMES(NF), .FRAME_DIV(FDIV),
    .BLINK_PERIOD(BP), .BLINK_COUNT(BC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .posx(posx), .posy(posy),
    .isplay(isplay), .vsync_tick(vsync_tick), .blink_req(blink_req),
    .rom_addr(rom_addr), .rom_data(rom_data), .color(color), .is_display(is_display)
  );

  // Synchronous ROM whose every word holds its own address
  always @(posedge clk) rom_data <= 16'(rom_addr);

  typedef struct { int due; logic disp; logic [15:0] col; int id; } exp_t;
  exp_t sb[$];
  exp_t e;
  int cyc = 0, n_assert = 0, n_fail = 0, n_id = 0;
  int m_ticks = 0, m_bt = 0;
  bit m_blink = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due == cyc) begin
          chk($sformatf("disp#%0d", e.id), 32'(is_display), 32'(e.disp));
          chk($sformatf("color#%0d", e.id), 32'(color), 32'(e.col));
        end else begin
          chk($sformatf("slot#%0d", e.id), cyc, e.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_addr(input int px, input int py);
    return ((m_ticks / FDIV) % NF) * W * H + (py - int'(posy)) * W + (px - int'(posx));
  endfunction

  task automatic pix(input int px, input int py);
    logic hit, v;
    logic [15:0] word;
    x = 10'(px);
    y = 9'(py);
    v = !m_blink || (m_bt / BP >= BC) || ((m_bt / BP) % 2 == 1);
    hit = isplay && v && px >= int'(posx) && px < int'(posx) + W &&
          py >= int'(posy) && py < int'(posy) + H;
    word = 16'(m_addr(px, py));
`ifdef HINT_SPRITE_TRANSPARENT_EN
    if (word == 16'h0000) hit = 1'b0;
`endif
    sb.push_back('{cyc + 2, hit, hit ? word : BG, n_id});
    n_id++;
    step();
  endtask

  task automatic pix_a(input int px, input int py, input string tag);
    x = 10'(px);
    y = 9'(py);
    #1;
    chk(tag, 32'(rom_addr), 32'(m_addr(px, py)));
    pix(px, py);
  endtask

  task automatic tick(input logic req);
    vsync_tick = 1'b1;
    blink_req  = req;
    x = '0;
    y = '0;
    step();
    vsync_tick = 1'b0;
    blink_req  = 1'b0;
    if (isplay) begin
      m_ticks++;
      if (req) begin
        m_blink = 1'b1;
        m_bt    = 0;
      end else if (m_blink) begin
        m_bt++;
      end
    end
  endtask

  task automatic req();
    blink_req = 1'b1;
    x = '0;
    step();
    blink_req = 1'b0;
    m_blink = 1'b1;
    m_bt    = 0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_color", 32'(color), 32'(BG));
    chk("rst_disp", 32'(is_display), 32'd0);
    rst_n = 1'b1;
    step();

    // full line scan across the sprite, plus vertical edges
    pix(99, 50);
    pix_a(100, 50, "addr_x100");
    for (int i = 101; i <= 275; i++) pix(i, 50);
    pix_a(276, 50, "addr_x276");
    pix(277, 50);
    pix(100, 49);
    pix(100, 75);
    pix(100, 76);

    // far right / bottom edges must not wrap
    posx = 10'd900;
    pix(1000, 50);
    pix(1023, 50);
    pix(5, 50);
    pix(899, 50);
    posy = 9'd490;
    pix(950, 500);
    pix(950, 3);
    posx = 10'd100;
    posy = 9'd50;

    // animation: frame address at sprite offset 0 after each tick
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      pix_a(100, 50, $sformatf("frame_addr%0d", i));
      pix(150, 60);
    end

    // isplay drop mid-line
    for (int i = 100; i < 105; i++) pix(i, 50);
    isplay = 1'b0;
    pix(105, 50);
    m_ticks = 0;
    m_blink = 1'b0;
    pix_a(100, 50, "off_frame0");
    tick(1'b0);
    pix_a(100, 50, "off_hold0");
    isplay = 1'b1;
    tick(1'b0);
    pix_a(100, 50, "on_div_reset");
    tick(1'b0);
    pix_a(100, 50, "on_frame1");

    // full blink sequence back to STEADY
    req();
    pix(120, 55);
    for (int i = 0; i < 100; i++) begin
      tick(1'b0);
      pix(120, 55);
    end

    // restart at tick 40
    req();
    for (int i = 0; i < 40; i++) tick(1'b0);
    pix(120, 55);
    req();
    for (int i = 0; i < 100; i++) begin
      tick(1'b0);
      pix(121, 55);
    end

    // blink_req coincident with the completing tick
    req();
    for (int i = 0; i < 95; i++) begin
      tick(1'b0);
      if (i % 8 == 0) pix(122, 56);
    end
    pix(122, 56);
    tick(1'b1);
    pix(122, 56);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      pix(123, 56);
    end

    // reset during BLINK_ON
    req();
    for (int i = 0; i < 20; i++) tick(1'b0);
    pix(120, 55);
    pix(121, 55);
    pix(121, 55);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_color", 32'(color), 32'(BG));
    chk("rst_mid_disp", 32'(is_display), 32'd0);
    sb.delete();
    m_ticks = 0;
    m_blink = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pix(120, 55);
    #1;
    chk("rst_first_edge", 32'(is_display), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      pix(124, 55);
    end

    x = '0;
    repeat (4) step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
